muldiv_unit: RTL and testbench

- Iterative unsigned multiply/divide unit. It owns and writes the HI/LO register pair that the ALU reads for its HI/LO read operations (op 3/4).
- Sits beside the ALU in the EX stage. The pipeline issues a multi-cycle op, stalls on busy, then reads hi/lo.
- Also supports single-cycle direct writes of HI and LO for move-to-HI/LO instructions.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : muldiv_unit                                                   |
// | Purpose  : Iterative unsigned multiply / divide unit owning the HI/LO    |
// |            register pair. MULTU and DIVU each take WIDTH clock steps;    |
// |            MTHI / MTLO write HI or LO directly in a single cycle.        |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst_n  - asynchronous active-low reset                        |
// |            start  - issue request, sampled at the rising edge            |
// |            op     - 5=MULTU 8=DIVU 9=MTHI 10=MTLO, other codes no-op     |
// |            a, b   - multiplicand/dividend/move source, multiplier/divisor|
// |            flush  - abort any in-flight operation (wins over start)      |
// |            hi, lo - HI/LO registers (upper product/remainder,            |
// |                     lower product/quotient)                              |
// |            busy   - an iterative operation is in progress                |
// |            done   - one-cycle pulse, hi/lo were updated this cycle       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] c_op_multu = 4'd5;
  localparam logic [3:0] c_op_divu  = 4'd8;
  localparam logic [3:0] c_op_mthi  = 4'd9;
  localparam logic [3:0] c_op_mtlo  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]     r_hi, w_hi_nxt;
  logic [WIDTH-1:0]     r_lo, w_lo_nxt;
  logic                 r_done, w_done_nxt;

  // Multiply working set: shifted multiplicand, shifting multiplier, accumulator
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;

  // Divide working set: dividend register doubles as quotient shift register
  logic [WIDTH-1:0]     r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0]     r_dsr, w_dsr_nxt;
  logic [WIDTH-1:0]     r_rem, w_rem_nxt;

  // One step of each algorithm, evaluated unconditionally
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_q_bit;
  logic [WIDTH-1:0]     w_rem_step;
  logic [WIDTH-1:0]     w_quo_step;

  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});
  assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
  assign w_q_bit    = (w_rem_sh >= {1'b0, r_dsr});
  // Once the bit is taken the difference is below the divisor, so the low
  // WIDTH bits of the subtraction carry the whole result.
  assign w_rem_step = w_q_bit ? (w_rem_sh[WIDTH-1:0] - r_dsr) : w_rem_sh[WIDTH-1:0];
  assign w_quo_step = {r_dvd[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_done   <= w_done_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dsr    <= w_dsr_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_done_nxt   = 1'b0;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_dvd_nxt    = r_dvd;
    w_dsr_nxt    = r_dsr;
    w_rem_nxt    = r_rem;

    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              c_op_multu: begin
                w_mcand_nxt  = {{WIDTH{1'b0}}, a};
                w_mplier_nxt = b;
                w_acc_nxt    = '0;
                w_cnt_nxt    = CNT_W'(WIDTH);
                w_state_nxt  = S_MUL;
              end
              c_op_divu: begin
                w_dvd_nxt   = a;
                w_dsr_nxt   = b;
                w_rem_nxt   = '0;
                w_cnt_nxt   = CNT_W'(WIDTH);
                w_state_nxt = S_DIV;
              end
              c_op_mthi: begin
                w_hi_nxt   = a;
                w_done_nxt = 1'b1;
              end
              c_op_mtlo: begin
                w_lo_nxt   = a;
                w_done_nxt = 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          w_acc_nxt    = w_acc_step;
          w_mcand_nxt  = {r_mcand[2*WIDTH-2:0], 1'b0};
          w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
          w_cnt_nxt    = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_hi_nxt    = w_acc_step[2*WIDTH-1:WIDTH];
            w_lo_nxt    = w_acc_step[WIDTH-1:0];
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_DIV: begin
          w_rem_nxt = w_rem_step;
          w_dvd_nxt = w_quo_step;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_hi_nxt    = w_rem_step;
            w_lo_nxt    = w_quo_step;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_muldiv_unit                                                |
// | Purpose  : Self-checking bench for muldiv_unit. Directed scenarios plus   |
// |            random MULTU/DIVU traffic compared against an arithmetic      |
// |            reference of the HI/LO pair.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       op = 4'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] hi, lo;
  logic             busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference HI/LO contents
  logic [WIDTH-1:0] hi_m = '0;
  logic [WIDTH-1:0] lo_m = '0;

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result of an iterative op as {hi, lo}
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] p;
    if (o == 4'd5) begin
      p = 64'(x) * 64'(y);
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  // Single-cycle op (MTHI/MTLO or a no-op code) issued from idle
  task automatic run_short(input string tag, input logic [3:0] o, input logic [31:0] x);
    logic exp_done;
    start = 1'b1; op = o; a = x; b = '0;
    @(posedge clk); #1;
    start = 1'b0;
    exp_done = 1'b0;
    if (o == 4'd9)  begin hi_m = x; exp_done = 1'b1; end
    if (o == 4'd10) begin lo_m = x; exp_done = 1'b1; end
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(exp_done));
    chk({tag, ".hi"}, 64'(hi), 64'(hi_m));
    chk({tag, ".lo"}, 64'(lo), 64'(lo_m));
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, 64'(done), 64'(0));
    chk({tag, ".busy_after"}, 64'(busy), 64'(0));
  endtask

  // Iterative op. On cycle inj_at (1-based, counted after the accept edge) a
  // second request is presented; with inj_flush it also carries flush.
  task automatic run_long(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int inj_at, input logic inj_flush,
                          input logic [3:0] inj_op, input logic [31:0] inj_a,
                          input logic hold_chk);
    int edges, busy_cnt, done_cnt;
    logic [63:0] r;
    logic flushed;
    edges = 0; busy_cnt = 0; done_cnt = 0; flushed = 1'b0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    while (!done && edges < 100) begin
      if (edges + 1 == inj_at) begin
        start = 1'b1; op = inj_op; a = inj_a; b = 32'd3; flush = inj_flush;
      end
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      edges++;
      if (inj_flush && edges == inj_at) begin
        flushed = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (busy && hold_chk) begin
        chk({tag, ".hold_hi"}, 64'(hi), 64'(hi_m));
        chk({tag, ".hold_lo"}, 64'(lo), 64'(lo_m));
      end
    end
    if (flushed) begin
      chk({tag, ".flush_busy"}, 64'(busy), 64'(0));
      chk({tag, ".flush_done"}, 64'(done), 64'(0));
      chk({tag, ".flush_hi"}, 64'(hi), 64'(hi_m));
      chk({tag, ".flush_lo"}, 64'(lo), 64'(lo_m));
      @(posedge clk); #1;
      chk({tag, ".flush_done2"}, 64'(done), 64'(0));
      chk({tag, ".flush_busy2"}, 64'(busy), 64'(0));
      chk({tag, ".flush_hi2"}, 64'(hi), 64'(hi_m));
      return;
    end
    r = ref_result(o, x, y);
    hi_m = r[63:32];
    lo_m = r[31:0];
    chk({tag, ".latency"}, 64'(edges), 64'(WIDTH));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    chk({tag, ".done_cnt"}, 64'(done_cnt), 64'(1));
    chk({tag, ".busy_end"}, 64'(busy), 64'(0));
    chk({tag, ".hi"}, 64'(hi), 64'(hi_m));
    chk({tag, ".lo"}, 64'(lo), 64'(lo_m));
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, 64'(done), 64'(0));
    chk({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        is_div;

    // Reset
    #12;
    chk("rst.hi", 64'(hi), 64'(0));
    chk("rst.lo", 64'(lo), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic arithmetic from the plan
    run_long("mul7x6", 4'd5, 32'd7, 32'd6, 0, 1'b0, 4'd0, 32'd0, 1'b1);
    run_long("mulmax", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 4'd0, 32'd0, 1'b1);
    run_long("div100_7", 4'd8, 32'd100, 32'd7, 0, 1'b0, 4'd0, 32'd0, 1'b1);
    run_long("div5_0", 4'd8, 32'd5, 32'd0, 0, 1'b0, 4'd0, 32'd0, 1'b1);

    // Direct writes and an ignored opcode
    run_short("mthi", 4'd9, 32'h1234);
    run_short("mtlo", 4'd10, 32'h5678);
    run_short("noop", 4'd3, 32'hCAFE);

    // MTHI issued while busy must be ignored
    run_long("mul3x3_mthi", 4'd5, 32'd3, 32'd3, 10, 1'b0, 4'd9, 32'hDEAD, 1'b1);

    // Start on the completing edge is dropped since busy is still high
    run_long("mul_b2b", 4'd5, 32'h0001_0003, 32'h0002_0005, WIDTH, 1'b0, 4'd10, 32'hBEEF, 1'b1);

    // Flush together with a start mid-multiply
    run_long("mul_flush", 4'd5, 32'h1_0000, 32'h1_0000, 15, 1'b1, 4'd5, 32'd9, 1'b1);
    run_long("mul2x3", 4'd5, 32'd2, 32'd3, 0, 1'b0, 4'd0, 32'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = ra >> $urandom_range(0, 4);
      endcase
      is_div = 1'($urandom_range(0, 1));
      run_long(is_div ? "rnd_div" : "rnd_mul", is_div ? 4'd8 : 4'd5, ra, rb,
               0, 1'b0, 4'd0, 32'd0, 1'b0);
    end

    // Asynchronous reset mid-divide
    run_short("mthi_pre", 4'd9, 32'hABCD);
    start = 1'b1; op = 4'd8; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    chk("arst.hi", 64'(hi), 64'(0));
    chk("arst.lo", 64'(lo), 64'(0));
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.done", 64'(done), 64'(0));
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("arst.idle_busy", 64'(busy), 64'(0));
      chk("arst.idle_done", 64'(done), 64'(0));
    end
    run_long("post_rst_div", 4'd8, 32'd1000, 32'd3, 0, 1'b0, 4'd0, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
